// File: rtl/intpol2_sched.sv
// Round-robin arbiter that time-shares one intpol2 core between NUM_CH channels:
// it latches the winner's config, pulses start, then waits for done or a timeout.
module intpol2_sched #(
    parameter int NUM_CH    = 4,
    parameter int CFG_WIDTH = 128,
    parameter int TIMEOUT   = 1024,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           req_i,
    input  logic [NUM_CH*CFG_WIDTH-1:0] ch_cfg_i,
    output logic [CFG_WIDTH-1:0]        core_config_o,
    output logic                        core_start_o,
    input  logic [7:0]                  core_status_i,
    output logic [NUM_CH-1:0]           ack_o,
    output logic                        err_o,
    output logic [CH_W-1:0]             grant_o,
    output logic                        active_o
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DONE,
        ABORT
    } state_t;

    state_t               state_reg, state_next;
    logic [TW-1:0]        timer_reg;
    logic [CH_W-1:0]      grant_reg;
    logic [CH_W-1:0]      last_reg;
    logic [CH_W-1:0]      pick;
    logic [CH_W-1:0]      idx;
    logic                 found;
    logic [CFG_WIDTH-1:0] config_reg;
    logic [CFG_WIDTH-1:0] cfg_slice [NUM_CH];
    logic                 unused_status;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slice
            assign cfg_slice[gi] = ch_cfg_i[gi*CFG_WIDTH +: CFG_WIDTH];
        end
    endgenerate

    // Walk from farthest to nearest so the channel right after last_reg wins.
    always_comb begin
        pick  = last_reg;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = CH_W'((int'(last_reg) + k) % NUM_CH);
            if (req_i[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (found) state_next = LOAD;
            LOAD:  state_next = START;
            START: state_next = RUN;
            RUN: begin
                // timer==0 masks a done left over from the previous job
                if (core_status_i[0] && timer_reg != '0)
                    state_next = DONE;
                else if (timer_reg == TW'(TIMEOUT - 1))
                    state_next = ABORT;
            end
            DONE:    state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            timer_reg  <= '0;
            grant_reg  <= '0;
            last_reg   <= CH_W'(NUM_CH - 1);
            config_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        grant_reg  <= pick;
                        config_reg <= cfg_slice[pick];
                    end
                end
                START:       timer_reg <= '0;
                RUN:         timer_reg <= timer_reg + TW'(1);
                DONE, ABORT: last_reg  <= grant_reg;
                default:     ;
            endcase
        end
    end

    always_comb begin
        ack_o = '0;
        if (state_reg == DONE || state_reg == ABORT)
            ack_o[grant_reg] = 1'b1;
    end

    assign err_o         = (state_reg == ABORT);
    assign core_start_o  = (state_reg == START);
    assign active_o      = (state_reg != IDLE);
    assign grant_o       = grant_reg;
    assign core_config_o = config_reg;
    // Busy is informational only; sequencing relies on done and the timer.
    assign unused_status = ^core_status_i[7:1];
endmodule

// File: tb/tb_intpol2_sched.sv
// Randomized bench for intpol2_sched: a cycle-counted core model feeds done,
// and job outcomes are predicted from round-robin order and RUN-window arithmetic.
module tb_intpol2_sched;
    localparam int NCH = 4;
    localparam int CW  = 128;
    localparam int TMO_M = 1024;
    localparam int TMO_T = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  req = '0;
    logic [NCH*CW-1:0] ch_cfg = '0;
    logic [7:0]      status = '0;

    logic [CW-1:0]   m_cfg, t_cfg;
    logic            m_start, t_start, m_err, t_err, m_active, t_active;
    logic [NCH-1:0]  m_ack, t_ack;
    logic [1:0]      m_grant, t_grant;

    logic [CW-1:0]   o_cfg;
    logic            o_start, o_err, o_active;
    logic [NCH-1:0]  o_ack;
    logic [1:0]      o_grant;
    bit              sel = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int delay = 3;
    bit hold = 1'b0;
    int done_at = -1;
    int model_last = 3;

    intpol2_sched #(.NUM_CH(NCH), .CFG_WIDTH(CW), .TIMEOUT(TMO_M)) dut_m (
        .clk(clk), .rst(rst), .req_i(req), .ch_cfg_i(ch_cfg),
        .core_config_o(m_cfg), .core_start_o(m_start), .core_status_i(status),
        .ack_o(m_ack), .err_o(m_err), .grant_o(m_grant), .active_o(m_active));

    intpol2_sched #(.NUM_CH(NCH), .CFG_WIDTH(CW), .TIMEOUT(TMO_T)) dut_t (
        .clk(clk), .rst(rst), .req_i(req), .ch_cfg_i(ch_cfg),
        .core_config_o(t_cfg), .core_start_o(t_start), .core_status_i(status),
        .ack_o(t_ack), .err_o(t_err), .grant_o(t_grant), .active_o(t_active));

    assign o_cfg    = sel ? t_cfg    : m_cfg;
    assign o_start  = sel ? t_start  : m_start;
    assign o_err    = sel ? t_err    : m_err;
    assign o_active = sel ? t_active : m_active;
    assign o_ack    = sel ? t_ack    : m_ack;
    assign o_grant  = sel ? t_grant  : m_grant;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: done appears 'delay' cycles after the start cycle, or is stuck high.
    always @(negedge clk) begin
        if (o_start) done_at = cyc + delay;
        status = {7'b0, hold || (cyc == done_at)};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    function automatic int rr_next(input int last, input logic [NCH-1:0] mask);
        for (int k = 1; k <= NCH; k++)
            if (mask[(last + k) % NCH]) return (last + k) % NCH;
        return -1;
    endfunction

    // RUN cycle s+1+j carries timer j; done counts from j>=1, abort after j==tmo-1.
    function automatic int expected_ack(input int s, input int d, input bit h,
                                        input int tmo, output bit e);
        int seen;
        seen = h ? s + 2 : s + d;
        if (seen <= s + tmo) begin
            e = 1'b0;
            return seen + 1;
        end
        e = 1'b1;
        return s + tmo + 1;
    endfunction

    function automatic logic [CW-1:0] slice(input int k);
        return ch_cfg[k*CW +: CW];
    endfunction

    task automatic rand_cfgs();
        for (int k = 0; k < NCH*CW/32; k++) ch_cfg[k*32 +: 32] = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = NCH - 1;
    endtask

    task automatic wait_start(output int t, output bit ok);
        ok = 1'b0; t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_start) begin t = cyc; ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ack(output int t, output logic [NCH-1:0] a, output bit e, output bit ok);
        ok = 1'b0; t = -1; a = '0; e = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_ack != '0) begin t = cyc; a = o_ack; e = o_err; ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rand_cfgs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_cfg, m_start, m_ack, m_err, m_grant, m_active} !== '0) begin
            errors++;
            $display("FAIL reset_m: start=%b ack=%b err=%b grant=%0d active=%b, required all 0",
                     m_start, m_ack, m_err, m_grant, m_active);
        end
        checks++;
        if ({t_cfg, t_start, t_ack, t_err, t_grant, t_active} !== '0) begin
            errors++;
            $display("FAIL reset_t: start=%b ack=%b err=%b grant=%0d active=%b, required all 0",
                     t_start, t_ack, t_err, t_grant, t_active);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_active !== 1'b0 || m_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: active=%b start=%b, required 0/0", m_active, m_start);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int r, s, a, exp_t; bit ok, e, exp_e; logic [NCH-1:0] ack;
        sel = 1'b0; do_reset();
        rand_cfgs();
        ch_cfg[31:0] = 32'd26;
        delay = 27;
        req = 4'b0001; r = cyc;
        wait_start(s, ok);
        checks++;
        if (!ok || s != r + 2) begin
            errors++; $display("FAIL single_latency: start at %0d, required %0d", s, r + 2);
        end
        checks++;
        if (o_cfg !== slice(0) || o_grant !== 2'd0) begin
            errors++; $display("FAIL single_cfg: cfg=%h grant=%0d, required %h / 0", o_cfg, o_grant, slice(0));
        end
        wait_ack(a, ack, e, ok);
        req = '0;
        exp_t = expected_ack(s, delay, hold, TMO_M, exp_e);
        checks++;
        if (!ok || a != exp_t || ack !== 4'b0001 || e !== exp_e) begin
            errors++;
            $display("FAIL single_ack: t=%0d ack=%b err=%b, required t=%0d ack=0001 err=%b", a, ack, e, exp_t, exp_e);
        end
        model_last = 0;
        $display("test_single: start=%0d ack=%0d", s, a);
    endtask

    task automatic test_round_robin();
        int s, a, prev_a, exp_ch, exp_t; bit ok, e, exp_e; logic [NCH-1:0] ack;
        sel = 1'b0; do_reset();
        rand_cfgs();
        delay = 3;
        req = 4'b1011;
        prev_a = -1;
        for (int j = 0; j < 6; j++) begin
            wait_start(s, ok);
            exp_ch = rr_next(model_last, req);
            checks++;
            if (!ok || o_grant !== 2'(exp_ch) || o_cfg !== slice(exp_ch)) begin
                errors++; $display("FAIL rr_grant[%0d]: grant=%0d, required %0d", j, o_grant, exp_ch);
            end
            if (prev_a >= 0) begin
                checks++;
                if (s != prev_a + 3) begin
                    errors++; $display("FAIL rr_gap[%0d]: start at %0d, required %0d", j, s, prev_a + 3);
                end
            end
            wait_ack(a, ack, e, ok);
            exp_t = expected_ack(s, delay, hold, TMO_M, exp_e);
            checks++;
            if (!ok || a != exp_t || ack !== 4'(1 << exp_ch) || e !== exp_e) begin
                errors++;
                $display("FAIL rr_ack[%0d]: t=%0d ack=%b err=%b, required t=%0d ch=%0d err=%b",
                         j, a, ack, e, exp_t, exp_ch, exp_e);
            end
            $display("rr job %0d: grant=%0d start=%0d ack=%0d", j, exp_ch, s, a);
            model_last = exp_ch;
            prev_a = a;
        end
        req = '0;
    endtask

    task automatic test_stale_done();
        int s, a; bit ok, e; logic [NCH-1:0] ack;
        sel = 1'b0; do_reset();
        hold = 1'b1;
        req = 4'b0100;
        wait_start(s, ok);
        wait_ack(a, ack, e, ok);
        req = '0;
        checks++;
        if (!ok || a != s + 3 || ack !== 4'b0100 || e !== 1'b0) begin
            errors++;
            $display("FAIL stale_done: t=%0d ack=%b err=%b, required t=%0d ack=0100 err=0", a, ack, e, s + 3);
        end
        hold = 1'b0;
        $display("test_stale_done: start=%0d ack=%0d", s, a);
    endtask

    task automatic test_timeout();
        int s, a, exp_t; bit ok, e, exp_e; logic [NCH-1:0] ack;
        sel = 1'b1; do_reset();
        rand_cfgs();
        delay = 1000;
        req = 4'b0011;
        wait_start(s, ok);
        wait_ack(a, ack, e, ok);
        delay = TMO_T;
        exp_t = expected_ack(s, 1000, 1'b0, TMO_T, exp_e);
        checks++;
        if (!ok || a != exp_t || ack !== 4'b0001 || e !== exp_e) begin
            errors++;
            $display("FAIL timeout_abort: t=%0d ack=%b err=%b, required t=%0d ack=0001 err=%b", a, ack, e, exp_t, exp_e);
        end
        $display("timeout job: start=%0d ack=%0d err=%b", s, a, e);
        wait_start(s, ok);
        checks++;
        if (!ok || o_grant !== 2'd1 || o_cfg !== slice(1)) begin
            errors++; $display("FAIL timeout_next: grant=%0d, required 1", o_grant);
        end
        wait_ack(a, ack, e, ok);
        req = '0;
        exp_t = expected_ack(s, TMO_T, 1'b0, TMO_T, exp_e);
        checks++;
        if (!ok || a != exp_t || ack !== 4'b0010 || e !== exp_e) begin
            errors++;
            $display("FAIL collision: t=%0d ack=%b err=%b, required t=%0d ack=0010 err=%b", a, ack, e, exp_t, exp_e);
        end
        $display("collision job: start=%0d ack=%0d err=%b", s, a, e);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        int s; bit ok; bit seen_ack;
        sel = 1'b0; do_reset();
        rand_cfgs();
        delay = 50;
        req = 4'b0010;
        wait_start(s, ok);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({m_cfg, m_start, m_ack, m_err, m_grant, m_active} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: grant=%0d active=%b ack=%b, required all 0", m_grant, m_active, m_ack);
        end
        seen_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m_ack != '0 || m_err) seen_ack = 1'b1;
        end
        req = 4'b0101;
        rst = 1'b0;
        model_last = NCH - 1;
        wait_start(s, ok);
        checks++;
        if (seen_ack) begin
            errors++; $display("FAIL reset_mid_noack: ack or err seen while in reset, required none");
        end
        checks++;
        if (!ok || o_grant !== 2'(rr_next(model_last, 4'b0101))) begin
            errors++; $display("FAIL reset_mid_grant: grant=%0d, required 0", o_grant);
        end
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset_mid: post-reset start=%0d grant=%0d", s, o_grant);
    endtask

    task automatic test_random();
        int s, a, prev_a, exp_ch, exp_t; bit ok, e, exp_e; logic [NCH-1:0] ack;
        logic [CW-1:0] exp_cfg;
        sel = 1'b0; do_reset();
        rand_cfgs();
        req = 4'($urandom_range(1, 15));
        delay = $urandom_range(2, 20);
        hold = ($urandom_range(0, 4) == 0);
        prev_a = -1;
        for (int j = 0; j < 20; j++) begin
            wait_start(s, ok);
            exp_ch = rr_next(model_last, req);
            exp_cfg = slice(exp_ch);
            checks++;
            if (!ok || o_grant !== 2'(exp_ch) || o_cfg !== exp_cfg) begin
                errors++; $display("FAIL rand_grant[%0d]: grant=%0d, required %0d", j, o_grant, exp_ch);
                break;
            end
            if (prev_a >= 0) begin
                checks++;
                if (s != prev_a + 3) begin
                    errors++; $display("FAIL rand_gap[%0d]: start at %0d, required %0d", j, s, prev_a + 3);
                end
            end
            rand_cfgs();
            if ($urandom_range(0, 2) == 0) req = '0;
            wait_ack(a, ack, e, ok);
            exp_t = expected_ack(s, delay, hold, TMO_M, exp_e);
            checks++;
            if (!ok || a != exp_t || ack !== 4'(1 << exp_ch) || e !== exp_e || o_cfg !== exp_cfg) begin
                errors++;
                $display("FAIL rand_ack[%0d]: t=%0d ack=%b err=%b, required t=%0d ch=%0d err=%b (cfg frozen)",
                         j, a, ack, e, exp_t, exp_ch, exp_e);
            end
            $display("rand job %0d: ch=%0d delay=%0d hold=%b start=%0d ack=%0d", j, exp_ch, delay, hold, s, a);
            model_last = exp_ch;
            prev_a = a;
            req = 4'($urandom_range(1, 15));
            delay = $urandom_range(2, 20);
            hold = ($urandom_range(0, 4) == 0);
        end
        req = '0; hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stale_done();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
